ram_pattern_tester: RTL and testbench

- Parametrised successor to the board-level RAM write/read exercise.
- Owns an inferred single-port RAM. Fills it with an arithmetic pattern, reads it back, compares every word, and reports the pass/fail result and error statistics.
- Sits behind the board key/kill inputs and drives the two board LEDs.
- Adds run modes, fault injection, error counting and a one-cycle-latency read pipeline.

---
 rtl/ram_pattern_tester.sv | 145 ++++++++++++++
 tb/tb_ram_pattern_tester.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_pattern_tester.sv
// RAM pattern tester: fills an inferred single-port RAM with an
// arithmetic pattern, reads it back and reports mismatch statistics.
module ram_pattern_tester #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int SEED   = 0,
  parameter int STEP   = 10
) (
  input  logic              clk,
  input  logic              kill,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              inject_err,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [1:0]        led
);

  typedef enum logic [2:0] {
    IDLE, FILL, VERIFY, DRAIN, DONE
  } state_t;

  localparam logic [DATA_W-1:0] SEED_V = DATA_W'(SEED);
  localparam logic [DATA_W-1:0] STEP_V = DATA_W'(STEP);
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  state_t            state;
  logic [1:0]        mode_q;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] exp_d;
  logic [ADDR_W-1:0] addr_d;
  logic              cmp_vld;

  logic              last;
  logic              we;
  logic              re;
  logic [DATA_W-1:0] wdata;
  logic              mismatch;
  logic [ADDR_W:0]   err_next;

  assign last     = (addr == LAST);
  assign we       = (state == FILL) && !kill;
  assign re       = (state == VERIFY) && !kill;
  assign wdata    = acc ^ DATA_W'(inject_err);
  assign mismatch = cmp_vld && (rdata != exp_d);
  assign err_next = err_count + (ADDR_W+1)'(mismatch);
  assign led      = {busy, pass};

  // RAM is never reset so contents survive a kill
  always_ff @(posedge clk) begin
    if (we)
      mem[addr] <= wdata;
    if (re)
      rdata <= mem[addr];
  end

  always_ff @(posedge clk) begin
    if (kill) begin
      state          <= IDLE;
      mode_q         <= '0;
      addr           <= '0;
      acc            <= SEED_V;
      exp_d          <= '0;
      addr_d         <= '0;
      cmp_vld        <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      done    <= 1'b0;
      cmp_vld <= 1'b0;
      if (mismatch) begin
        err_count <= err_next;
        if (err_count == '0)
          first_err_addr <= addr_d;
      end
      case (state)
        IDLE: begin
          if (start) begin
            mode_q         <= mode;
            err_count      <= '0;
            first_err_addr <= '0;
            pass           <= 1'b0;
            addr           <= '0;
            acc            <= SEED_V;
            busy           <= 1'b1;
            state          <= (mode == 2'd2) ? VERIFY : FILL;
          end
        end
        FILL: begin
          if (last) begin
            addr <= '0;
            acc  <= SEED_V;
            if (mode_q == 2'd1) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state <= VERIFY;
            end
          end else begin
            addr <= addr + 1'b1;
            acc  <= acc + STEP_V;
          end
        end
        VERIFY: begin
          // expected word and address ride one cycle behind the read
          cmp_vld <= 1'b1;
          exp_d   <= acc;
          addr_d  <= addr;
          if (last) begin
            state <= DRAIN;
          end else begin
            addr <= addr + 1'b1;
            acc  <= acc + STEP_V;
          end
        end
        DRAIN: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (err_next == '0);
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_pattern_tester.sv
// Randomized self-checking bench for ram_pattern_tester against
// a word-level model of the RAM and the pattern.
module tb_ram_pattern_tester;

  logic       clk = 1'b0;
  logic       kill_s  [2];
  logic       start_s [2];
  logic [1:0] mode_s  [2];
  logic       inj_s   [2];
  logic       busy_s  [2];
  logic       done_s  [2];
  logic       pass_s  [2];
  logic [8:0] err_s   [2];
  logic [7:0] fea_s   [2];
  logic [1:0] led_s   [2];

  int checks = 0;
  int failures = 0;
  int depth [2] = '{16, 256};
  int seed  [2] = '{3, 0};
  int mdl   [2][256];

  always #5 clk = ~clk;

  ram_pattern_tester #(
    .DATA_W(8), .ADDR_W(8), .DEPTH(16),
    .SEED(3), .STEP(10)
  ) u_a (
    .clk(clk), .kill(kill_s[0]),
    .start(start_s[0]), .mode(mode_s[0]),
    .inject_err(inj_s[0]), .busy(busy_s[0]),
    .done(done_s[0]), .pass(pass_s[0]),
    .err_count(err_s[0]),
    .first_err_addr(fea_s[0]), .led(led_s[0])
  );

  ram_pattern_tester #(
    .DATA_W(8), .ADDR_W(8), .DEPTH(256),
    .SEED(0), .STEP(10)
  ) u_b (
    .clk(clk), .kill(kill_s[1]),
    .start(start_s[1]), .mode(mode_s[1]),
    .inject_err(inj_s[1]), .busy(busy_s[1]),
    .done(done_s[1]), .pass(pass_s[1]),
    .err_count(err_s[1]),
    .first_err_addr(fea_s[1]), .led(led_s[1])
  );

  task automatic check(input string tag,
                       input longint obs,
                       input longint exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  function automatic int pat(input int u, input int a);
    return (seed[u] + 10 * a) % 256;
  endfunction

  task automatic check_idle_zero(input int u);
    check("z_busy", busy_s[u], 0);
    check("z_done", done_s[u], 0);
    check("z_pass", pass_s[u], 0);
    check("z_err", err_s[u], 0);
    check("z_fea", fea_s[u], 0);
    check("z_led", led_s[u], 0);
  endtask

  // im: 0 no injection, 1 only at address ia, 2 random words
  task automatic run(input int u, input logic [1:0] m,
                     input int im, input int ia,
                     input bit p2, input logic [1:0] m2);
    int d, dc, errs, first;
    bit fill, ver;
    bit inj [256];
    d = depth[u];
    fill = (m != 2'd2);
    ver = (m != 2'd1);
    for (int a = 0; a < d; a++)
      inj[a] = (im == 1) ? (a == ia) :
               (im == 2) ? ($urandom_range(0, 5) == 0) : 1'b0;
    if (fill)
      for (int a = 0; a < d; a++)
        mdl[u][a] = pat(u, a) ^ int'(inj[a]);
    errs = 0;
    first = 0;
    if (ver)
      for (int a = 0; a < d; a++)
        if (mdl[u][a] != pat(u, a)) begin
          if (errs == 0) first = a;
          errs++;
        end
    dc = (m == 2'd1) ? d + 1 : (m == 2'd2) ? d + 2 : 2 * d + 2;
    @(negedge clk);
    start_s[u] = 1'b1;
    mode_s[u] = m;
    inj_s[u] = 1'($urandom_range(0, 1));
    for (int c = 1; c <= dc; c++) begin
      @(negedge clk);
      check("busy", busy_s[u], c < dc);
      check("done", done_s[u], c == dc);
      start_s[u] = p2 && (c == 10);
      if (p2 && c >= 10) mode_s[u] = m2;
      inj_s[u] = (fill && c <= d) ? inj[c-1] :
                 1'($urandom_range(0, 1));
    end
    check("err", err_s[u], ver ? errs : 0);
    check("fea", fea_s[u], ver ? first : 0);
    check("pass", pass_s[u], ver ? (errs == 0) : 1);
    check("led", led_s[u], ver ? (errs == 0) : 1);
    @(negedge clk);
    start_s[u] = 1'b0;
    inj_s[u] = 1'b0;
    check("done_end", done_s[u], 0);
    check("busy_end", busy_s[u], 0);
    check("pass_hold", pass_s[u], ver ? (errs == 0) : 1);
  endtask

  initial begin
    int n_done, c1, c2, c;
    for (int u = 0; u < 2; u++) begin
      kill_s[u] = 1'b1;
      start_s[u] = 1'b0;
      mode_s[u] = 2'd0;
      inj_s[u] = 1'b0;
    end
    repeat (3) @(negedge clk);
    kill_s[0] = 1'b0;
    kill_s[1] = 1'b0;
    @(negedge clk);
    check_idle_zero(0);
    check_idle_zero(1);

    run(0, 2'd0, 0, 0, 1'b0, 2'd0);
    run(0, 2'd0, 1, 5, 1'b0, 2'd0);
    check("mem5", u_a.mem[5], 52);
    run(0, 2'd1, 0, 0, 1'b0, 2'd0);
    run(0, 2'd2, 0, 0, 1'b0, 2'd0);

    for (int i = 0; i < 8; i++)
      run(0, 2'($urandom_range(0, 3)),
          2 * $urandom_range(0, 1), 0,
          1'($urandom_range(0, 1)),
          2'($urandom_range(0, 3)));

    // kill mid-fill over an already clean pattern
    run(0, 2'd1, 0, 0, 1'b0, 2'd0);
    @(negedge clk);
    start_s[0] = 1'b1;
    mode_s[0] = 2'd0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      start_s[0] = 1'b0;
      kill_s[0] = (k == 8);
    end
    @(negedge clk);
    kill_s[0] = 1'b0;
    check_idle_zero(0);
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      n_done += int'(done_s[0]);
    end
    check("kill_nodone", n_done, 0);
    run(0, 2'd2, 0, 0, 1'b0, 2'd0);

    // second start mid-run must not relaunch or re-latch mode
    run(0, 2'd0, 0, 0, 1'b1, 2'd1);

    // start held high relaunches straight after DONE
    @(negedge clk);
    start_s[0] = 1'b1;
    mode_s[0] = 2'd1;
    c1 = 0;
    c2 = 0;
    c = 0;
    while (c < 60 && c2 == 0) begin
      @(negedge clk);
      c++;
      if (done_s[0]) begin
        if (c1 == 0) c1 = c;
        else c2 = c;
      end
      if (c1 != 0 && c == c1 + 1)
        check("hold_idle", busy_s[0], 0);
      if (c1 != 0 && c == c1 + 2) begin
        check("hold_busy", busy_s[0], 1);
        start_s[0] = 1'b0;
      end
    end
    start_s[0] = 1'b0;
    check("hold_done1", c1, 17);
    check("hold_done2", c2, 35);
    repeat (2) @(negedge clk);

    run(1, 2'd1, 0, 0, 1'b0, 2'd0);
    check("mem26", u_b.mem[26], 4);
    run(1, 2'd0, 0, 0, 1'b0, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
